// File: rtl/encoder_4to2_queued.sv
// Sequential 4-to-2 priority encoder: sticky request capture, one code issued at a time
// under a valid/ack handshake. The returned code drives a 2x4 one-hot decoder downstream.
module encoder_4to2_queued #(
  parameter bit HIGH_FIRST = 1'b1,
  parameter bit EDGE       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic ack,
  output logic y0,
  output logic y1,
  output logic valid,
  output logic lost
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     r_state;
  logic [3:0] r_pending;
  logic [3:0] r_prev;
  logic [1:0] r_y;
  logic       r_valid;
  logic       r_lost;

  logic [3:0] w_in;
  logic [3:0] w_cap;
  logic [1:0] w_sel;
  logic       w_load;
  logic [3:0] w_issue_mask;
  logic [3:0] w_inflight;
  logic       w_hit;

  assign w_in  = {i3, i2, i1, i0};
  assign w_cap = EDGE ? (w_in & ~r_prev) : w_in;

  // Selection looks only at the registered pending set, never at this cycle's capture.
  always_comb begin
    w_sel = 2'd0;
    if (HIGH_FIRST) begin
      if      (r_pending[3]) w_sel = 2'd3;
      else if (r_pending[2]) w_sel = 2'd2;
      else if (r_pending[1]) w_sel = 2'd1;
      else                   w_sel = 2'd0;
    end else begin
      if      (r_pending[0]) w_sel = 2'd0;
      else if (r_pending[1]) w_sel = 2'd1;
      else if (r_pending[2]) w_sel = 2'd2;
      else if (r_pending[3]) w_sel = 2'd3;
    end
  end

  assign w_load       = (r_pending != 4'b0000) && (!r_valid || ack);
  assign w_issue_mask = w_load ? (4'b0001 << w_sel) : 4'b0000;
  assign w_inflight   = r_valid ? (4'b0001 << r_y) : 4'b0000;
  assign w_hit        = EDGE && (|(w_cap & (r_pending | w_inflight)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= 4'b0000;
      r_prev    <= 4'b0000;
      r_y       <= 2'b00;
      r_valid   <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      // A capture on the bit being issued this cycle wins, so that bit stays pending.
      r_pending <= (r_pending & ~w_issue_mask) | w_cap;
      r_prev    <= w_in;
      if (w_hit) r_lost <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state <= HOLD;
            r_y     <= w_sel;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (ack) begin
            if (w_load) begin
              r_y <= w_sel;
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign y0    = r_y[0];
  assign y1    = r_y[1];
  assign valid = r_valid;
  assign lost  = r_lost;

endmodule

// File: tb/tb_encoder_4to2_queued.sv
// Scoreboard bench for encoder_4to2_queued: three instances cover HIGH_FIRST/EDGE variants;
// expected codes are queued with the stimulus and popped on every accepted handshake.
module tb_encoder_4to2_queued;

  logic clk;
  logic rst;

  logic [3:0] req_a, req_b, req_c;
  logic       ack_a, ack_b, ack_c;
  logic [1:0] y_a, y_b, y_c;
  logic       v_a, v_b, v_c;
  logic       l_a, l_b, l_c;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [1:0] q_c[$];

  int n_vec;
  int n_err;

  // a: HIGH_FIRST=1 level capture; b: HIGH_FIRST=0 level capture; c: HIGH_FIRST=1 edge capture
  encoder_4to2_queued #(.HIGH_FIRST(1'b1), .EDGE(1'b0)) u_a (
    .clk(clk), .rst(rst), .i0(req_a[0]), .i1(req_a[1]), .i2(req_a[2]), .i3(req_a[3]),
    .ack(ack_a), .y0(y_a[0]), .y1(y_a[1]), .valid(v_a), .lost(l_a));

  encoder_4to2_queued #(.HIGH_FIRST(1'b0), .EDGE(1'b0)) u_b (
    .clk(clk), .rst(rst), .i0(req_b[0]), .i1(req_b[1]), .i2(req_b[2]), .i3(req_b[3]),
    .ack(ack_b), .y0(y_b[0]), .y1(y_b[1]), .valid(v_b), .lost(l_b));

  encoder_4to2_queued #(.HIGH_FIRST(1'b1), .EDGE(1'b1)) u_c (
    .clk(clk), .rst(rst), .i0(req_c[0]), .i1(req_c[1]), .i2(req_c[2]), .i3(req_c[3]),
    .ack(ack_c), .y0(y_c[0]), .y1(y_c[1]), .valid(v_c), .lost(l_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accepted handshake = valid && ack sampled mid-cycle, retired at the next rising edge.
  always @(negedge clk) begin
    if (!rst && v_a && ack_a) begin
      if (q_a.size() == 0) chk("a_unexpected_issue", {6'b0, y_a}, 8'hFF);
      else                 chk("a_code", {6'b0, y_a}, {6'b0, q_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && v_b && ack_b) begin
      if (q_b.size() == 0) chk("b_unexpected_issue", {6'b0, y_b}, 8'hFF);
      else                 chk("b_code", {6'b0, y_b}, {6'b0, q_b.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && v_c && ack_c) begin
      if (q_c.size() == 0) chk("c_unexpected_issue", {6'b0, y_c}, 8'hFF);
      else                 chk("c_code", {6'b0, y_c}, {6'b0, q_c.pop_front()});
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    req_a = 4'b0; req_b = 4'b0; req_c = 4'b0;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    #12;
    chk("reset_a", {4'b0, l_a, v_a, y_a}, 8'h00);
    chk("reset_b", {4'b0, l_b, v_b, y_b}, 8'h00);
    chk("reset_c", {4'b0, l_c, v_c, y_c}, 8'h00);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Latency: request seen at edge k, valid with code only after edge k+1.
    req_a = 4'b1000;
    tick(1);
    chk("lat_edge_k_valid", {7'b0, v_a}, 8'h00);
    req_a = 4'b0000;
    tick(1);
    chk("lat_edge_k1", {6'b0, v_a, y_a[1]}, {6'b0, 1'b1, 1'b1});
    chk("lat_code", {6'b0, y_a}, 8'h03);
    q_a.push_back(2'd3);
    ack_a = 1'b1;
    tick(1);
    chk("lat_idle", {7'b0, v_a}, 8'h00);
    ack_a = 1'b0;
    tick(1);

    // All four lines for one cycle, ack held high: 3,2,1,0 back-to-back.
    q_a.push_back(2'd3); q_a.push_back(2'd2); q_a.push_back(2'd1); q_a.push_back(2'd0);
    ack_a = 1'b1;
    req_a = 4'b1111;
    tick(1);
    req_a = 4'b0000;
    tick(1);
    chk("burst_first", {5'b0, v_a, y_a}, 8'h07);
    tick(1);
    chk("burst_second", {5'b0, v_a, y_a}, 8'h06);
    tick(1);
    chk("burst_third", {5'b0, v_a, y_a}, 8'h05);
    tick(1);
    chk("burst_fourth", {5'b0, v_a, y_a}, 8'h04);
    tick(1);
    chk("burst_idle", {7'b0, v_a}, 8'h00);
    chk("burst_drained", 8'(q_a.size()), 8'h00);
    ack_a = 1'b0;
    tick(1);

    // Issue and re-capture of i2 in the same cycle: i2 issues twice.
    q_a.push_back(2'd2); q_a.push_back(2'd2);
    ack_a = 1'b1;
    req_a = 4'b0100;
    tick(2);
    chk("same_cycle_first", {5'b0, v_a, y_a}, 8'h06);
    req_a = 4'b0000;
    tick(1);
    chk("same_cycle_reissue", {5'b0, v_a, y_a}, 8'h06);
    tick(1);
    chk("same_cycle_idle", {7'b0, v_a}, 8'h00);
    chk("same_cycle_drained", 8'(q_a.size()), 8'h00);
    chk("level_lost_a", {7'b0, l_a}, 8'h00);
    ack_a = 1'b0;

    // Low-first priority: {i3,i1} pending, code 01 held while unacked.
    req_b = 4'b1010;
    tick(1);
    req_b = 4'b0000;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("lowfirst_hold", {5'b0, v_b, y_b}, 8'h05);
      tick(1);
    end
    q_b.push_back(2'd1); q_b.push_back(2'd3);
    ack_b = 1'b1;
    tick(1);
    chk("lowfirst_next", {5'b0, v_b, y_b}, 8'h07);
    tick(1);
    chk("lowfirst_idle", {7'b0, v_b}, 8'h00);
    chk("lowfirst_drained", 8'(q_b.size()), 8'h00);
    chk("level_lost_b", {7'b0, l_b}, 8'h00);
    ack_b = 1'b0;

    // Edge capture: i1 held 10 cycles issues once.
    q_c.push_back(2'd1);
    ack_c = 1'b1;
    req_c = 4'b0010;
    tick(10);
    chk("edge_single_idle", {7'b0, v_c}, 8'h00);
    chk("edge_single_drained", 8'(q_c.size()), 8'h00);
    chk("edge_no_lost", {7'b0, l_c}, 8'h00);
    req_c = 4'b0000;
    ack_c = 1'b0;
    tick(1);
    req_c = 4'b0010;
    tick(1);
    req_c = 4'b0000;
    tick(1);
    chk("edge_inflight", {4'b0, l_c, v_c, y_c}, 8'h05);
    req_c = 4'b0010;
    tick(1);
    chk("edge_lost_set", {7'b0, l_c}, 8'h01);
    req_c = 4'b0000;
    q_c.push_back(2'd1); q_c.push_back(2'd1);
    ack_c = 1'b1;
    tick(1);
    chk("edge_reissue", {5'b0, v_c, y_c}, 8'h05);
    tick(1);
    chk("edge_idle", {6'b0, l_c, v_c}, 8'h02);
    chk("edge_drained", 8'(q_c.size()), 8'h00);
    ack_c = 1'b0;

    // Asynchronous reset in the middle of a hold.
    req_a = 4'b0100;
    tick(1);
    req_a = 4'b0000;
    tick(1);
    chk("pre_reset_hold", {5'b0, v_a, y_a}, 8'h06);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_a", {4'b0, l_a, v_a, y_a}, 8'h00);
    chk("async_reset_c_lost", {7'b0, l_c}, 8'h00);
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("post_reset_idle", {7'b0, v_a}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_4to2_queued.md
Name: encoder_4to2_queued

Overview:
Sequential 4-to-2 priority encoder. It performs the reverse of the team's 2x4 one-hot decoder.
- Captures requests on four one-hot/any-hot lines i0..i3 into a sticky pending register.
- Issues the binary index of one pending request at a time on {y1,y0}, under a valid/ack handshake.
- Sits between event sources and any consumer that drives the 2x4 decoder with the returned code.

Parameters:
HIGH_FIRST  1  1: i3 has highest priority, i0 lowest; 0: i0 highest, i3 lowest
EDGE        0  0: level capture (input high sets pending every cycle); 1: rising-edge capture only

Ports:
clk    input   1  clock, all state updates on rising edge
rst    input   1  asynchronous, active-high reset
i0     input   1  request line 0
i1     input   1  request line 1
i2     input   1  request line 2
i3     input   1  request line 3
ack    input   1  consumer accepts current code this cycle (counts only when valid=1)
y0     output  1  code bit 0 (LSB) of issued request index
y1     output  1  code bit 1 (MSB) of issued request index
valid  output  1  {y1,y0} holds an issued, unacknowledged code
lost   output  1  sticky: an EDGE-mode rising edge hit a line already pending or in flight

Behaviour:
- Reset (async, rst=1): pending=4'b0000, prev=4'b0000, valid=0, y1=0, y0=0, lost=0. The state machine goes to IDLE. Reset mid-handshake discards the in-flight code and all pending requests.
- Capture vector cap[3:0], sampled on each clk rising edge:
  - EDGE=0: cap = {i3,i2,i1,i0}.
  - EDGE=1: cap = {i3..i0} & ~prev; prev <= {i3..i0}.
  - After reset, prev=0, so a line already high at the first edge counts as a rising edge.
- Pending update: pending <= (pending & ~issue_mask) | cap. A capture on the same bit being issued in that cycle wins, so the bit stays pending.
- Select: sel = highest-priority set bit of pending (register value, not this cycle's cap), ordered by HIGH_FIRST. issue_mask = one-hot of sel when a load occurs, else 0.
- Load condition: load = (pending != 0) && (valid==0 || ack==1).
- State machine:
  - IDLE (valid=0):
    - load -> HOLD; y <= sel index; valid <= 1.
    - Otherwise stay in IDLE.
  - HOLD (valid=1), by ack and load:
    - ack=0: hold; y and valid stable, regardless of new requests.
    - ack=1 and load: stay in HOLD; load the next sel (back-to-back issue, no bubble).
    - ack=1 and no load: -> IDLE; valid <= 0; y keeps its last value.
- ack while valid=0 is ignored.
- Latency: a request sampled at edge k is in pending after edge k. The earliest valid with its code is after edge k+1. Minimum request-to-valid latency is 2 cycles.
- Throughput: one code per cycle while ack is held high and pending is non-empty.
- Merging: multiple captures of a line already pending collapse into one issue.
  - EDGE=1: lost <= 1 if cap[n]=1 and the line is already pending, or is the in-flight code (valid=1, y=n). lost clears only on reset.
  - EDGE=0: lost stays 0.
- Codes: {y1,y0} = 2'b00..2'b11 for i0..i3. A code never appears with valid=0 as a new issue.

Test Plan:
1. rst pulse mid-HOLD (i2 issued, no ack) -> immediately valid=0, y=00, lost=0; after release with inputs 0, valid stays 0.
2. HIGH_FIRST=1, EDGE=0: pulse i0..i3 all high for one cycle, ack held 1 -> codes 11,10,01,00 on four consecutive cycles, then valid=0.
3. HIGH_FIRST=0: pending={i3,i1}, ack=0 for 5 cycles -> y=01 held stable with valid=1. ack=1 -> next cycle y=11; then valid=0.
4. EDGE=1: i1 held high 10 cycles -> exactly one issue of 01, lost=0. Drop i1 and re-raise it while code 01 is still unacked -> lost=1, a second 01 is issued after ack.
5. Simultaneous events: i2 issued and i2 re-captured in the same cycle (EDGE=0, ack=1) -> i2 remains pending and re-issues as 10 the next cycle.
6. Latency: i3 raised before edge k, pending previously empty -> valid=1, y=11 after edge k+1, not before.
